// File: rtl/serial_bus_pkg.sv
// Shared definitions for both ends of the serial bus: FSM states, frame
// start marker, field encodings and the control-frame length helper.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        WAIT_ACK,
        WRITE,
        READ,
        FINISH
    } bus_state_t;

    localparam logic [2:0] FRAME_START = 3'b111;

    localparam logic RW_WRITE  = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic BURST_ON  = 1'b1;
    localparam logic BURST_OFF = 1'b0;

    // start(3) + slave id + rw(1) + burst(1) + address
    function automatic int ctrl_len(input int sid_w, input int addr_w);
        return 5 + sid_w + addr_w;
    endfunction

endpackage

// File: rtl/serial_bus_master_port_if.sv
// Serial bus wires between one master and the interconnect/slaves.
interface serial_bus_master_port_if;

    logic control;
    logic wD;
    logic valid;
    logic last;
    logic rD;
    logic ready;

    modport master (
        output control, wD, valid, last,
        input  rD, ready
    );

    modport slave (
        input  control, wD, valid, last,
        output rD, ready
    );

endinterface

// File: rtl/serial_bus_shifter.sv
// MSB-first shift register with parallel load and a count of bits shifted
// since the last load/clear. Used for the frame, write and read paths.
module serial_bus_shifter
    import serial_bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    // clear beats load beats shift; the new bit enters at the LSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_data;
            cnt  <= '0;
        end else if (shift) begin
            data <= {data[WIDTH-2:0], sin};
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_bus_master_port.sv
// Serial bus master endpoint: takes a parallel host command, sends the control
// frame on `control`, then streams write words out on `wD` or collects read
// words from `rD`, pacing every data bit on the slave's `ready`.
module serial_bus_master_port
    import serial_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int SID_WIDTH  = 3,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SID_WIDTH-1:0]  cmd_slave_id,
    input  logic                  cmd_write,
    input  logic                  cmd_burst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  error,
    serial_bus_master_port_if.master bus
);

    localparam int CTRL_LEN = ctrl_len(SID_WIDTH, ADDR_WIDTH);
    localparam int FCW      = $clog2(CTRL_LEN + 1);
    localparam int DCW      = $clog2(DATA_WIDTH + 1);
    localparam int TW       = $clog2(TIMEOUT + 1);

    localparam logic [FCW-1:0] FRAME_END  = FCW'(CTRL_LEN - 1);
    localparam logic [DCW-1:0] BIT_LAST   = DCW'(DATA_WIDTH - 1);
    localparam logic [DCW-1:0] BIT_PENULT = DCW'(DATA_WIDTH - 2);
    localparam logic [TW-1:0]  WAIT_END   = TW'(TIMEOUT - 1);

    bus_state_t state, state_nxt;

    logic [CTRL_LEN-1:0]   frame_q;
    logic [FCW-1:0]        frame_cnt;
    logic [DATA_WIDTH-1:0] wr_q, rd_q;
    logic [DCW-1:0]        wr_cnt, rd_cnt;

    logic                 rw_mode;
    logic                 wloaded, wloaded_nxt;
    logic [LEN_WIDTH-1:0] widx, widx_nxt;
    logic [LEN_WIDTH-1:0] last_idx, last_idx_nxt;
    logic [TW-1:0]        wcnt, wcnt_nxt;

    logic valid_r, last_r;
    logic valid_nxt, last_nxt, cmd_ready_nxt, wr_ready_nxt;
    logic rd_valid_nxt, done_nxt, error_nxt;
    logic [DATA_WIDTH-1:0] rd_data_nxt;

    logic frame_load, frame_shift, wr_load, wr_shift, rd_shift, rd_clr;

    // Only the MSB of the frame/write shifters and the low bits of the read
    // shifter leave this block; the rest is internal storage.
    logic unused_bits;
    assign unused_bits = ^{frame_q[CTRL_LEN-2:0], wr_q[DATA_WIDTH-2:0], rd_q[DATA_WIDTH-1]};

    serial_bus_shifter #(.WIDTH(CTRL_LEN), .CNT_W(FCW)) u_frame (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(frame_load),
        .load_data({FRAME_START, cmd_slave_id, cmd_write, cmd_burst, cmd_addr}),
        .shift(frame_shift), .sin(1'b0),
        .data(frame_q), .cnt(frame_cnt)
    );

    serial_bus_shifter #(.WIDTH(DATA_WIDTH), .CNT_W(DCW)) u_wr (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(wr_load), .load_data(wr_data),
        .shift(wr_shift), .sin(1'b0),
        .data(wr_q), .cnt(wr_cnt)
    );

    serial_bus_shifter #(.WIDTH(DATA_WIDTH), .CNT_W(DCW)) u_rd (
        .clk(clk), .rst(rst), .clr(rd_clr),
        .load(1'b0), .load_data('0),
        .shift(rd_shift), .sin(bus.rD),
        .data(rd_q), .cnt(rd_cnt)
    );

    // Shifters hold zeros outside their active phase, so the bus lines idle low.
    assign bus.control = frame_q[CTRL_LEN-1];
    assign bus.wD      = wr_q[DATA_WIDTH-1];
    assign bus.valid   = valid_r;
    assign bus.last    = last_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_nxt     = state;
        frame_load    = 1'b0;
        frame_shift   = 1'b0;
        wr_load       = 1'b0;
        wr_shift      = 1'b0;
        rd_shift      = 1'b0;
        rd_clr        = 1'b0;
        wloaded_nxt   = wloaded;
        widx_nxt      = widx;
        last_idx_nxt  = last_idx;
        wcnt_nxt      = wcnt;
        valid_nxt     = 1'b0;
        last_nxt      = last_r;
        cmd_ready_nxt = 1'b0;
        wr_ready_nxt  = 1'b0;
        rd_valid_nxt  = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        rd_data_nxt   = rd_data;

        unique case (state)
            IDLE: begin
                last_nxt = 1'b0;
                if (cmd_valid) begin
                    frame_load   = 1'b1;
                    last_idx_nxt = (cmd_burst == BURST_ON) ? cmd_len : '0;
                    widx_nxt     = '0;
                    valid_nxt    = 1'b1;
                    state_nxt    = CTRL;
                end else begin
                    cmd_ready_nxt = 1'b1;
                end
            end
            CTRL: begin
                frame_shift = 1'b1;
                valid_nxt   = 1'b1;
                if (frame_cnt == FRAME_END) begin
                    wcnt_nxt  = '0;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                valid_nxt = 1'b1;
                if (bus.ready) begin
                    if (rw_mode == RW_READ) begin
                        rd_clr    = 1'b1;
                        state_nxt = READ;
                    end else begin
                        wloaded_nxt  = 1'b0;
                        wr_ready_nxt = 1'b1;
                        valid_nxt    = 1'b0;
                        state_nxt    = WRITE;
                    end
                end else if (wcnt == WAIT_END) begin
                    error_nxt     = 1'b1;
                    valid_nxt     = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            WRITE: begin
                if (!wloaded) begin
                    // stall with valid low until the host supplies a word
                    if (wr_valid && wr_ready) begin
                        wr_load     = 1'b1;
                        wloaded_nxt = 1'b1;
                        valid_nxt   = 1'b1;
                    end else begin
                        wr_ready_nxt = 1'b1;
                    end
                end else begin
                    valid_nxt = 1'b1;
                    if (bus.ready) begin
                        wr_shift = 1'b1;
                        if (wr_cnt == BIT_LAST) begin
                            wloaded_nxt = 1'b0;
                            valid_nxt   = 1'b0;
                            last_nxt    = 1'b0;
                            if (widx == last_idx) begin
                                done_nxt  = 1'b1;
                                state_nxt = FINISH;
                            end else begin
                                widx_nxt     = widx + 1'b1;
                                wr_ready_nxt = 1'b1;
                            end
                        end else if (wr_cnt == BIT_PENULT && widx == last_idx) begin
                            last_nxt = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                valid_nxt = 1'b1;
                if (bus.ready) begin
                    if (rd_cnt == BIT_LAST) begin
                        // completed word goes straight to rd_data; shifter restarts
                        rd_clr       = 1'b1;
                        rd_data_nxt  = {rd_q[DATA_WIDTH-2:0], bus.rD};
                        rd_valid_nxt = 1'b1;
                        last_nxt     = 1'b0;
                        if (widx == last_idx) begin
                            valid_nxt = 1'b0;
                            done_nxt  = 1'b1;
                            state_nxt = FINISH;
                        end else begin
                            widx_nxt = widx + 1'b1;
                        end
                    end else begin
                        rd_shift = 1'b1;
                        if (rd_cnt == BIT_PENULT && widx == last_idx) last_nxt = 1'b1;
                    end
                end
            end
            FINISH: begin
                cmd_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                cmd_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
        endcase
    end

    // Datapath counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_mode   <= RW_READ;
            wloaded   <= 1'b0;
            widx      <= '0;
            last_idx  <= '0;
            wcnt      <= '0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (frame_load) rw_mode <= cmd_write;
            wloaded   <= wloaded_nxt;
            widx      <= widx_nxt;
            last_idx  <= last_idx_nxt;
            wcnt      <= wcnt_nxt;
            valid_r   <= valid_nxt;
            last_r    <= last_nxt;
            cmd_ready <= cmd_ready_nxt;
            wr_ready  <= wr_ready_nxt;
            rd_valid  <= rd_valid_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
            rd_data   <= rd_data_nxt;
        end
    end

endmodule

// File: doc/serial_bus_master_port.md
# serial_bus_master_port

Master-side endpoint of the team's serial bus: the initiator that the UART slave system and other bus slaves answer to. Accepts parallel read/write commands from a host, serialises the control frame (start|slave id|R/W|burst|start address) onto `control`, then shifts write data out on `wD` or collects read data from `rD` under the `valid`/`ready` handshake. Sits between the system controller and the bus interconnect, one instance per master.

## Interface
- `DATA_WIDTH`, 8: bits per data word.
- `ADDR_WIDTH`, 12: start-address field width.
- `SID_WIDTH`, 3: slave-id field width.
- `LEN_WIDTH`, 4: burst length field; word count = `cmd_len`+1.
- `TIMEOUT`, 255: cycles to wait for slave `ready` before aborting.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` / `cmd_ready` in/out 1: host command handshake.
- `cmd_slave_id` in SID_WIDTH; `cmd_write` in 1 (1 = write); `cmd_burst` in 1; `cmd_addr` in ADDR_WIDTH; `cmd_len` in LEN_WIDTH.
- `wr_data` in DATA_WIDTH, `wr_valid` in 1, `wr_ready` out 1: write-word stream.
- `rd_data` out DATA_WIDTH, `rd_valid` out 1: read word, one-cycle pulse.
- `done` out 1: one-cycle pulse at transaction end; `error` out 1: one-cycle pulse on timeout.
- `control` out 1, `wD` out 1, `valid` out 1, `last` out 1: serial bus, master-driven.
- `rD` in 1, `ready` in 1: serial bus, slave-driven.

## Operation
- Frame: 3'b111, slave id, rw, burst, addr; MSB first; CTRL_LEN = 5+SID_WIDTH+ADDR_WIDTH (20 default).
- Non-burst forces word count 1 regardless of `cmd_len`.
- FSM states: IDLE, CTRL, WAIT_ACK, WRITE, READ, FINISH.
- IDLE: `cmd_ready`=1; on `cmd_valid` latch command, load frame shifter, go CTRL.
- CTRL: drive one frame bit per cycle on `control`, `valid`=1; after CTRL_LEN bits go WAIT_ACK with `control`=0.
- WAIT_ACK: `valid`=1; count cycles; `ready`=1 -> WRITE or READ; count reaches TIMEOUT -> `error` pulse, IDLE.
- WRITE: `wr_ready`=1 when word shifter empty; word loaded on `wr_valid&&wr_ready`. Bit shifted on `wD` MSB first, advance only when `ready`=1; `valid`=0 while no word loaded (stall). `last`=1 during final bit of final word. After final bit accepted -> FINISH.
- READ: `valid`=1; bit of `rD` sampled into shifter on each cycle `ready`=1, MSB first; on DATA_WIDTH-th bit `rd_data` updated, `rd_valid` pulses. `last`=1 while the final word's final bit is pending. Final word -> FINISH.
- FINISH: outputs idle, `done` pulse, IDLE.
- `ready` drop mid-word: hold current bit and counters, no timeout in WRITE/READ.
- `cmd_valid` in non-IDLE states ignored (`cmd_ready`=0).

## Timing
- Reset values: `control`=`wD`=`valid`=`last`=0, `cmd_ready`=1, `wr_ready`=`rd_valid`=`done`=`error`=0, `rd_data`=0; FSM IDLE. Reset mid-transaction returns all outputs to these values immediately.
- All outputs registered. Command accepted at edge T: first frame bit (1) on `control` from T+1 to T+2; last frame bit at T+CTRL_LEN.
- Write: each bit consumes exactly one `ready`-high cycle; burst of N words, continuous `ready` and `wr_valid`: N·DATA_WIDTH cycles after ack plus one load cycle per word.
- `rd_valid` asserted the cycle after the last bit of a word is sampled.
- `done` one cycle after final bit; `cmd_ready` high the cycle after `done`.
- Timeout: `error` at ack-wait cycle TIMEOUT, no `done`.

## Structure
- Package `serial_bus_pkg`: state enum, frame start constant 3'b111, CTRL_LEN function, rw/burst bit encodings; shared with slave side.
- One sub-module: `serial_bus_shifter` (parallel-load, shift-enable, MSB-first in/out, bit counter), instantiated for frame, write and read paths.

## Test plan
- Write id 4, addr 12'h0A5, non-burst, data 8'hC3, `ready` tied high after frame -> `control` carries 111_100_1_0_000010100101, `wD` 11000011, `last` on final bit, `done` pulse.
- Burst read id 2, len 3 (4 words), slave returns 8'h11,22,33,44 -> four `rd_valid` pulses with those values, `last` only on word 4 bit 0.
- Write with `ready` toggling every other cycle and `wr_valid` gap of 5 cycles -> `wD` sequence unchanged, `valid`=0 during gap, no data loss.
- Slave never acks, TIMEOUT=255 -> `error` pulse at cycle 255 of WAIT_ACK, outputs idle, next command accepted.
- `rst` asserted during word 2 of a burst write -> all outputs reset asynchronously, new command afterward completes normally.
- `cmd_valid` held during active transaction -> ignored, accepted only after `done`.
